regfile_wport_arbiter: RTL and testbench

//   Owns the single write port of the core register file. After reset it sweeps

---
 rtl/regfile_wport_arbiter.sv | 121 ++++++++++++
 tb/tb_regfile_wport_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wport_arbiter.sv
// Write-port owner for the core register file.
// After reset it clears every register, one per cycle. It then arbitrates
// the single write port between the pipeline writeback (core) and one
// long-latency result source (ext). Core has priority. A starvation guard
// stalls the core so that ext is served after a bounded wait.
module regfile_wport_arbiter #(
  parameter int NUM_REGS   = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  localparam int ADDR_W    = $clog2(NUM_REGS),
  localparam int WAIT_W    = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_rd,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              stall_core,
  input  logic              ext_valid,
  output logic              ext_ready,
  input  logic [ADDR_W-1:0] ext_rd,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              init_busy
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] SWEEP_LAST = ADDR_W'(NUM_REGS - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX   = WAIT_W'(STARVE_MAX);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] sweep_cnt;
  logic [ADDR_W-1:0] sweep_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;

  logic core_req;
  logic ext_req;
  logic force_ext;
  logic grant_ext;

  // Register 0 is hardwired, so a write aimed at it is not a real request.
  // Ext still completes its handshake in that case, and the data is dropped.
  always_comb begin
    core_req  = core_we & (|core_rd);
    ext_req   = ext_valid & (|ext_rd);
    force_ext = (wait_cnt == WAIT_MAX) & ext_valid;
    grant_ext = ext_valid & (~core_req | force_ext);
  end

  // Update the control state. Reset restarts the sweep and clears any
  // accumulated ext wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      sweep_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      sweep_cnt <= sweep_nxt;
      wait_cnt  <= wait_nxt;
    end
  end

  // Compute the next state and drive the zero-latency write port outputs.
  // While rst is high, the outputs already show the first sweep cycle
  // (address 0), whatever state is currently held.
  always_comb begin
    state_nxt  = state;
    sweep_nxt  = sweep_cnt;
    wait_nxt   = wait_cnt;
    rf_we      = 1'b0;
    rf_rd      = '0;
    rf_wdata   = '0;
    init_busy  = 1'b0;
    stall_core = 1'b0;
    ext_ready  = 1'b0;

    if (rst || (state == ST_INIT)) begin
      rf_we      = 1'b1;
      rf_rd      = rst ? '0 : sweep_cnt;
      init_busy  = 1'b1;
      stall_core = 1'b1;
      sweep_nxt  = sweep_cnt + ADDR_W'(1);
      wait_nxt   = '0;
      if (sweep_cnt == SWEEP_LAST) begin
        state_nxt = ST_RUN;
      end
    end else begin
      ext_ready  = grant_ext;
      // A forced ext slot makes the core hold its writeback for one cycle.
      // The core write is not lost: it lands on a later cycle.
      stall_core = force_ext;
      if (grant_ext) begin
        rf_we = ext_req;
        if (ext_req) begin
          rf_rd    = ext_rd;
          rf_wdata = ext_wdata;
        end
      end else if (core_req) begin
        rf_we    = 1'b1;
        rf_rd    = core_rd;
        rf_wdata = core_wdata;
      end

      if (!ext_valid || grant_ext) begin
        wait_nxt = '0;
      end else if (wait_cnt != WAIT_MAX) begin
        wait_nxt = wait_cnt + WAIT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Bench for regfile_wport_arbiter: directed scenarios followed by random
// traffic. Every cycle is checked against a cycle-level behavioural model.
module tb_regfile_wport_arbiter;

  localparam int NUM_REGS   = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
  localparam int ADDR_W     = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              core_we;
  logic [ADDR_W-1:0] core_rd;
  logic [DATA_W-1:0] core_wdata;
  logic              stall_core;
  logic              ext_valid;
  logic              ext_ready;
  logic [ADDR_W-1:0] ext_rd;
  logic [DATA_W-1:0] ext_wdata;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_wdata;
  logic              init_busy;

  always #5 clk = ~clk;

  regfile_wport_arbiter #(
    .NUM_REGS  (NUM_REGS),
    .DATA_W    (DATA_W),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .core_we   (core_we),
    .core_rd   (core_rd),
    .core_wdata(core_wdata),
    .stall_core(stall_core),
    .ext_valid (ext_valid),
    .ext_ready (ext_ready),
    .ext_rd    (ext_rd),
    .ext_wdata (ext_wdata),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_wdata  (rf_wdata),
    .init_busy (init_busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Model state: still sweeping, sweep position, and ext wait in cycles.
  bit m_init  = 1'b1;
  int m_sweep = 0;
  int m_wait  = 0;
  // The model's view of the last cycle, used by the stimulus drivers.
  bit m_gext  = 1'b0;
  bit m_stall = 1'b0;

  // DUT outputs sampled during the last step.
  logic              o_rdy, o_stall, o_we, o_busy;
  logic [ADDR_W-1:0] o_rd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Runs one clock cycle. It applies the inputs, checks the outputs
  // mid-cycle against the model, and advances the model at the edge.
  task automatic step(input bit r, input bit cwe, input logic [4:0] crd, input logic [31:0] cdat,
                      input bit ev, input logic [4:0] erd, input logic [31:0] edat);
    bit e_we, e_busy, e_stall, e_rdy, creq, frc;
    int e_rd;
    logic [31:0] e_wd;
    bit n_init;
    int n_sweep, n_wait;
    rst = r; core_we = cwe; core_rd = crd; core_wdata = cdat;
    ext_valid = ev; ext_rd = erd; ext_wdata = edat;
    #3;
    n_init = m_init; n_sweep = m_sweep; n_wait = m_wait;
    e_we = 0; e_rd = 0; e_wd = 0; e_busy = 0; e_stall = 0; e_rdy = 0;
    if (r) begin
      e_we = 1; e_busy = 1; e_stall = 1;
      n_init = 1; n_sweep = 0; n_wait = 0;
    end else if (m_init) begin
      e_we = 1; e_rd = m_sweep; e_busy = 1; e_stall = 1;
      n_sweep = m_sweep + 1;
      if (n_sweep == NUM_REGS) begin n_init = 0; n_sweep = 0; end
      n_wait = 0;
    end else begin
      creq  = cwe && (crd != 0);
      frc   = (m_wait == STARVE_MAX) && ev;
      e_rdy = ev && (!creq || frc);
      e_stall = frc;
      if (e_rdy) begin
        if (erd != 0) begin e_we = 1; e_rd = erd; e_wd = edat; end
      end else if (creq) begin
        e_we = 1; e_rd = crd; e_wd = cdat;
      end
      if (!ev || e_rdy) n_wait = 0;
      else n_wait = (m_wait + 1 > STARVE_MAX) ? STARVE_MAX : m_wait + 1;
    end
    check("rf_we", rf_we, e_we);
    check("rf_rd", rf_rd, e_rd);
    check("rf_wdata", rf_wdata, e_wd);
    check("init_busy", init_busy, e_busy);
    check("stall_core", stall_core, e_stall);
    check("ext_ready", ext_ready, e_rdy);
    o_rdy = ext_ready; o_stall = stall_core; o_we = rf_we; o_busy = init_busy; o_rd = rf_rd;
    @(posedge clk);
    #1;
    m_init = n_init; m_sweep = n_sweep; m_wait = n_wait;
    m_gext = e_rdy; m_stall = e_stall;
  endtask

  // The core writes on every cycle and holds its write while stalled.
  // Ext (rd 7) is pending from the first cycle, so it must be refused for
  // STARVE_MAX cycles and forced on the next one. The held core write then
  // lands on the cycle after that.
  task automatic flood(input string tag);
    logic [4:0] crd;
    crd = 5'd10;
    for (int i = 0; i <= STARVE_MAX + 1; i++) begin
      step(0, 1, crd, {27'h0, crd} + 32'h100, i <= STARVE_MAX, 5'd7, 32'h1234);
      if (i <= STARVE_MAX) begin
        check($sformatf("%s_rdy%0d", tag, i), o_rdy, i == STARVE_MAX);
        check($sformatf("%s_stall%0d", tag, i), o_stall, i == STARVE_MAX);
      end
      if (i == STARVE_MAX) check($sformatf("%s_ext_rd", tag), o_rd, 7);
      if (i == STARVE_MAX + 1) check($sformatf("%s_core_late", tag), o_rd, crd);
      if (!m_stall) crd = crd + 5'd1;
    end
  endtask

  initial begin
    bit cwe, ev;
    logic [4:0]  crd, erd;
    logic [31:0] cdat, edat;

    rst = 1; core_we = 0; core_rd = 0; core_wdata = 0;
    ext_valid = 0; ext_rd = 0; ext_wdata = 0;
    @(posedge clk);
    #1;

    // Reset, then a full sweep. Ext must not be accepted during it.
    step(1, 0, 0, 0, 1, 5'd3, 32'h55);
    check("rst_we", o_we, 1);
    for (int i = 0; i < NUM_REGS; i++) begin
      step(0, 1, 5'd9, 32'h99, 1, 5'd3, 32'h55);
      check($sformatf("init_rd%0d", i), o_rd, i);
    end
    step(0, 0, 0, 0, 1, 5'd3, 32'h55);
    check("run_busy", o_busy, 0);
    check("run_first_rdy", o_rdy, 1);

    // A plain core write goes through on the same cycle.
    step(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
    check("core_rd5", o_rd, 5);

    // Starvation guard.
    flood("starve");

    // Writes to register 0.
    step(0, 1, 5'd0, 32'hAAAA, 0, 0, 0);
    check("core_r0_we", o_we, 0);
    step(0, 0, 5'd0, 0, 1, 5'd0, 32'hBBBB);
    check("ext_r0_rdy", o_rdy, 1);
    check("ext_r0_we", o_we, 0);

    // An idle core lets ext through at once, and the wait count stays at 0.
    step(0, 0, 0, 0, 1, 5'd31, 32'hCAFE);
    check("ext_idle_rd", o_rd, 31);
    flood("after_idle");

    // A reset in the middle of the sweep restarts it from register 0.
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < NUM_REGS; i++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      check($sformatf("resweep_rd%0d", i), o_rd, i);
    end

    // A reset after ext has waited 3 cycles: the wait starts over after init.
    for (int i = 0; i < 3; i++) step(0, 1, 5'd12, 32'h12, 1, 5'd7, 32'h1234);
    step(1, 1, 5'd12, 32'h12, 1, 5'd7, 32'h1234);
    for (int i = 0; i < NUM_REGS; i++) step(0, 1, 5'd12, 32'h12, 1, 5'd7, 32'h1234);
    flood("post_rst");

    // Random traffic. Both sources follow their hold rules.
    cwe = 0; crd = 0; cdat = 0; ev = 0; erd = 0; edat = 0;
    for (int i = 0; i < 600; i++) begin
      if (!m_stall) begin
        cwe  = ($urandom_range(0, 3) != 0);
        crd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        cdat = $urandom;
      end
      if (!ev || m_gext) begin
        ev   = ($urandom_range(0, 1) == 1);
        erd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        edat = $urandom;
      end
      step($urandom_range(0, 99) == 0, cwe, crd, cdat, ev, erd, edat);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
